// File: rtl/mem_arb_pkg.sv
// Shared types, widths and the round-robin search used by the memory/lock arbiter.
// The lock-entry struct is sized by LADR_W below; the top's LADR_W must match it.
package mem_arb_pkg;

  localparam int unsigned LADR_W = 10;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OWN_W  = 8;
  localparam int unsigned MAX_C  = 32;

  typedef struct packed {
    logic              valid;
    logic [OWN_W-1:0]  owner;
    logic [LADR_W-1:0] adr;
  } lock_entry_t;

  // Index of the first set bit at or after ptr (wrapping at n), or -1 when req is empty.
  function automatic int rr_search(input logic [MAX_C-1:0] req, input int unsigned ptr,
                                   input int unsigned n);
    int          sel;
    int unsigned idx;
    sel = -1;
    for (int unsigned k = 0; k < MAX_C; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && sel < 0 && idx < MAX_C && req[idx]) sel = int'(idx);
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: first requester at or after ptr, wrapping at C-1.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned C = 8,
  localparam int unsigned PTR_W = (C > 1) ? $clog2(C) : 1
) (
  input  logic [C-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [C-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic [MAX_C-1:0] req_ext;
  int               sel;

  always_comb begin
    req_ext        = '0;
    req_ext[C-1:0] = req;
    sel            = rr_search(req_ext, 32'(ptr), C);
    gnt            = '0;
    gnt_idx        = '0;
    any            = 1'b0;
    if (sel >= 0) begin
      any     = 1'b1;
      gnt_idx = PTR_W'(sel);
      for (int unsigned i = 0; i < C; i++) gnt[i] = (sel == int'(i));
    end
  end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Round-robin main-memory arbiter with a per-core lock/unlock unit.
// Define MEM_LOCK_ARB_LOCK_EN to build the lock table; otherwise lock_ac just acknowledges.
module mem_lock_arbiter #(
  parameter int unsigned C      = 8,
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LADR_W = mem_arb_pkg::LADR_W
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [C-1:0]                          rd_req,
  input  logic [C-1:0]                          wr_req,
  input  logic [C-1:0][mem_arb_pkg::DATA_W-1:0] rd_adr,
  input  logic [C-1:0][mem_arb_pkg::DATA_W-1:0] wr_adr,
  input  logic [C-1:0][mem_arb_pkg::DATA_W-1:0] wr_dat,
  output logic [C-1:0]                          mem_ac,
  output logic [mem_arb_pkg::DATA_W-1:0]        mem_adr,
  output logic [mem_arb_pkg::DATA_W-1:0]        mem_wdat,
  output logic                                  mem_we,
  input  logic [C-1:0][LADR_W-1:0]              lock_adr,
  input  logic [C-1:0]                          lock_en,
  input  logic [C-1:0]                          unlock_en,
  output logic [C-1:0]                          lock_ac
);
  import mem_arb_pkg::*;

  localparam int unsigned PTR_W = (C > 1) ? $clog2(C) : 1;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(C - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  // ---------------- memory arbitration ----------------
  logic [C-1:0]      wr_first, mem_cand, mem_gnt;
  logic [PTR_W-1:0]  mem_gidx, rr_mem_q, rr_mem_d;
  logic              mem_any, gnt_is_wr;
  logic [C-1:0]      wr_done_q, wr_done_d;
  logic [C-1:0]      mem_ac_q, mem_ac_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_adr_q, mem_adr_d, mem_wdat_q, mem_wdat_d;

  // wr_done marks a core whose write went out while its read is still pending.
  assign wr_first = wr_req & ~(wr_done_q & rd_req);
  assign mem_cand = (rd_req | wr_first) & ~mem_ac_q;

  rr_pick #(
    .C(C)
  ) u_mem_pick (
    .req    (mem_cand),
    .ptr    (rr_mem_q),
    .gnt    (mem_gnt),
    .gnt_idx(mem_gidx),
    .any    (mem_any)
  );

  always_comb begin
    gnt_is_wr  = wr_first[mem_gidx];
    mem_ac_d   = mem_any ? mem_gnt : '0;
    mem_we_d   = mem_any & gnt_is_wr;
    mem_adr_d  = mem_adr_q;
    mem_wdat_d = mem_wdat_q;
    rr_mem_d   = rr_mem_q;
    wr_done_d  = wr_done_q & rd_req;
    if (mem_any) begin
      mem_adr_d           = gnt_is_wr ? wr_adr[mem_gidx] : rd_adr[mem_gidx];
      mem_wdat_d          = wr_dat[mem_gidx];
      rr_mem_d            = ptr_next(mem_gidx);
      wr_done_d[mem_gidx] = gnt_is_wr & rd_req[mem_gidx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_ac_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_adr_q  <= '0;
      mem_wdat_q <= '0;
      rr_mem_q   <= '0;
      wr_done_q  <= '0;
    end else begin
      mem_ac_q   <= mem_ac_d;
      mem_we_q   <= mem_we_d;
      mem_adr_q  <= mem_adr_d;
      mem_wdat_q <= mem_wdat_d;
      rr_mem_q   <= rr_mem_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign mem_ac   = mem_ac_q;
  assign mem_we   = mem_we_q;
  assign mem_adr  = mem_adr_q;
  assign mem_wdat = mem_wdat_q;

  // ---------------- lock / unlock ----------------
  logic [C-1:0]     lock_req, lock_gnt, lock_ac_q, lock_ac_d;
  logic [PTR_W-1:0] lock_gidx, rr_lock_q, rr_lock_d;
  logic             lock_any;

`ifdef MEM_LOCK_ARB_LOCK_EN
  lock_entry_t  tbl_q [LOCK_N];
  lock_entry_t  tbl_d [LOCK_N];
  logic [C-1:0] unl_pend, lk_own, lk_taken, lk_ok;
  logic         unl_mode, free_any;
  int unsigned  free_idx;

  // Unlocks pre-empt locks; locks that cannot be granted are filtered before the picker.
  always_comb begin
    unl_pend = unlock_en & ~lock_ac_q;
    unl_mode = |unl_pend;
    free_any = 1'b0;
    free_idx = 0;
    lk_own   = '0;
    lk_taken = '0;
    for (int unsigned n = LOCK_N; n > 0; n--) begin
      if (!tbl_q[n-1].valid) begin
        free_any = 1'b1;
        free_idx = n - 1;
      end
    end
    for (int unsigned i = 0; i < C; i++) begin
      for (int unsigned n = 0; n < LOCK_N; n++) begin
        if (tbl_q[n].valid && tbl_q[n].adr == lock_adr[i]) begin
          lk_taken[i] = 1'b1;
          if (tbl_q[n].owner == OWN_W'(i)) lk_own[i] = 1'b1;
        end
      end
    end
    lk_ok    = lk_own | (~lk_taken & {C{free_any}});
    lock_req = unl_mode ? unl_pend : (lock_en & ~lock_ac_q & lk_ok);
  end

  always_comb begin
    tbl_d = tbl_q;
    if (lock_any) begin
      if (unl_mode) begin
        for (int unsigned n = 0; n < LOCK_N; n++) begin
          if (tbl_q[n].valid && tbl_q[n].owner == OWN_W'(lock_gidx) &&
              tbl_q[n].adr == lock_adr[lock_gidx]) begin
            tbl_d[n] = '0;
          end
        end
      end else if (!lk_own[lock_gidx]) begin
        tbl_d[free_idx] = '{valid: 1'b1, owner: OWN_W'(lock_gidx), adr: lock_adr[lock_gidx]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < LOCK_N; n++) begin
      if (!reset_n) tbl_q[n] <= '0;
      else          tbl_q[n] <= tbl_d[n];
    end
  end
`else
  logic unused_lock_adr;
  assign unused_lock_adr = ^lock_adr;
  assign lock_req        = (lock_en | unlock_en) & ~lock_ac_q;
`endif

  rr_pick #(
    .C(C)
  ) u_lock_pick (
    .req    (lock_req),
    .ptr    (rr_lock_q),
    .gnt    (lock_gnt),
    .gnt_idx(lock_gidx),
    .any    (lock_any)
  );

  assign lock_ac_d = lock_any ? lock_gnt : '0;
  assign rr_lock_d = lock_any ? ptr_next(lock_gidx) : rr_lock_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_ac_q <= '0;
      rr_lock_q <= '0;
    end else begin
      lock_ac_q <= lock_ac_d;
      rr_lock_q <= rr_lock_d;
    end
  end

  assign lock_ac = lock_ac_q;

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed bench for mem_lock_arbiter; lock-table scenarios follow MEM_LOCK_ARB_LOCK_EN.
module tb_mem_lock_arbiter;
  localparam int unsigned C      = 8;
  localparam int unsigned LADR_W = 10;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [C-1:0]           rd_req, wr_req, lock_en, unlock_en;
  logic [C-1:0][15:0]     rd_adr, wr_adr, wr_dat;
  logic [C-1:0][LADR_W-1:0] lock_adr;
  logic [C-1:0]           mem_ac, lock_ac;
  logic [15:0]            mem_adr, mem_wdat;
  logic                   mem_we;

  int total = 0;
  int bad   = 0;

  mem_lock_arbiter #(
    .C     (C),
    .LOCK_N(4),
    .LADR_W(LADR_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .rd_adr   (rd_adr),
    .wr_adr   (wr_adr),
    .wr_dat   (wr_dat),
    .mem_ac   (mem_ac),
    .mem_adr  (mem_adr),
    .mem_wdat (mem_wdat),
    .mem_we   (mem_we),
    .lock_adr (lock_adr),
    .lock_en  (lock_en),
    .unlock_en(unlock_en),
    .lock_ac  (lock_ac)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req = '0; wr_req = '0; lock_en = '0; unlock_en = '0;
    rd_adr = '0; wr_adr = '0; wr_dat = '0; lock_adr = '0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    wr_req = 8'hFF; rd_req = 8'hFF; lock_en = 8'hFF;
    for (int i = 0; i < C; i++) begin wr_adr[i] = 16'h7700 + 16'(i); wr_dat[i] = 16'h5500; end
    tick(); tick();
    total++; if (mem_ac !== 8'h00) begin bad++; $display("FAIL rst_mem_ac: got %h want 00", mem_ac); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    total++; if (mem_adr !== 16'h0) begin bad++; $display("FAIL rst_mem_adr: got %h want 0", mem_adr); end
    total++; if (mem_wdat !== 16'h0) begin bad++; $display("FAIL rst_mem_wdat: got %h want 0", mem_wdat); end
    total++; if (lock_ac !== 8'h00) begin bad++; $display("FAIL rst_lock_ac: got %h want 00", lock_ac); end
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    rd_adr[2] = 16'h0040;
    rd_req    = 8'h04;
    tick();
    total++; if (mem_ac !== 8'h04) begin bad++; $display("FAIL rd_ac: got %h want 04", mem_ac); end
    total++; if (mem_adr !== 16'h0040) begin bad++; $display("FAIL rd_adr: got %h want 0040", mem_adr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_we: got %b want 0", mem_we); end
    rd_req = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (mem_ac !== 8'h00 || mem_we !== 1'b0 || mem_adr !== 16'h0040) begin
        bad++;
        $display("FAIL idle_hold: got ac=%h we=%b adr=%h want ac=00 we=0 adr=0040",
                 mem_ac, mem_we, mem_adr);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_ac;
    int         c;
    pulse_reset();
    for (int i = 0; i < C; i++) begin
      wr_adr[i] = 16'h0200 + 16'(i);
      wr_dat[i] = 16'hA000 + 16'(i);
    end
    wr_req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      c      = k % 8;
      exp_ac = 8'h01 << c;
      total++;
      if (mem_ac !== exp_ac || mem_we !== 1'b1 || mem_wdat !== 16'hA000 + 16'(c) ||
          mem_adr !== 16'h0200 + 16'(c)) begin
        bad++;
        $display("FAIL rr_grant%0d: got ac=%h we=%b adr=%h wdat=%h want ac=%h we=1 adr=%h wdat=%h",
                 k, mem_ac, mem_we, mem_adr, mem_wdat, exp_ac, 16'h0200 + 16'(c),
                 16'hA000 + 16'(c));
      end
    end
    // Reset with requests held: pending grant dropped, restart from core 0.
    reset_n = 1'b0;
    tick();
    total++; if (mem_ac !== 8'h00) begin bad++; $display("FAIL midrst_ac: got %h want 00", mem_ac); end
    reset_n = 1'b1;
    tick();
    total++; if (mem_ac !== 8'h01) begin bad++; $display("FAIL midrst_regrant: got %h want 01", mem_ac); end
    clear_inputs();
  endtask

  task automatic test_wr_before_rd();
    pulse_reset();
    wr_adr[3] = 16'h0010; rd_adr[3] = 16'h0020; wr_dat[3] = 16'hBEEF;
    wr_req = 8'h08; rd_req = 8'h08;
    tick();
    total++;
    if (mem_ac !== 8'h08 || mem_we !== 1'b1 || mem_adr !== 16'h0010 || mem_wdat !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_first: got ac=%h we=%b adr=%h wdat=%h want ac=08 we=1 adr=0010 wdat=beef",
               mem_ac, mem_we, mem_adr, mem_wdat);
    end
    tick();
    total++; if (mem_ac !== 8'h00) begin bad++; $display("FAIL wr_mask: got %h want 00", mem_ac); end
    tick();
    total++;
    if (mem_ac !== 8'h08 || mem_we !== 1'b0 || mem_adr !== 16'h0020) begin
      bad++;
      $display("FAIL rd_after_wr: got ac=%h we=%b adr=%h want ac=08 we=0 adr=0020",
               mem_ac, mem_we, mem_adr);
    end
    clear_inputs();
  endtask

  task automatic test_dual_grant();
    pulse_reset();
    rd_adr[4] = 16'h0123; lock_adr[4] = 10'h02A;
    rd_req = 8'h10; lock_en = 8'h10;
    tick();
    total++;
    if (mem_ac !== 8'h10 || lock_ac !== 8'h10 || mem_adr !== 16'h0123) begin
      bad++;
      $display("FAIL dual_grant: got mem_ac=%h lock_ac=%h adr=%h want 10 10 0123",
               mem_ac, lock_ac, mem_adr);
    end
    clear_inputs();
  endtask

`ifdef MEM_LOCK_ARB_LOCK_EN
  task automatic test_lock_contend();
    pulse_reset();
    lock_adr[1] = 10'h155; lock_adr[5] = 10'h155;
    lock_en = 8'h22;
    tick();
    total++; if (lock_ac !== 8'h02) begin bad++; $display("FAIL contend_first: got %h want 02", lock_ac); end
    lock_en = 8'h20;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (lock_ac !== 8'h00) begin bad++; $display("FAIL contend_wait: got %h want 00", lock_ac); end
    end
    unlock_en = 8'h02;
    tick();
    total++; if (lock_ac !== 8'h02) begin bad++; $display("FAIL contend_unlock: got %h want 02", lock_ac); end
    unlock_en = 8'h00;
    tick();
    total++; if (lock_ac !== 8'h20) begin bad++; $display("FAIL contend_second: got %h want 20", lock_ac); end
    clear_inputs();
  endtask

  task automatic test_lock_full();
    logic [7:0] pend;
    pulse_reset();
    for (int i = 0; i < 5; i++) lock_adr[i] = 10'h010 + 10'(i);
    pend = 8'h1F;
    for (int i = 0; i < 4; i++) begin
      lock_en = pend;
      tick();
      total++;
      if (lock_ac !== (8'h01 << i)) begin
        bad++;
        $display("FAIL full_ack%0d: got %h want %h", i, lock_ac, 8'h01 << i);
      end
      pend[i] = 1'b0;
    end
    lock_en = pend;
    tick();
    total++; if (lock_ac !== 8'h00) begin bad++; $display("FAIL full_wait: got %h want 00", lock_ac); end
    unlock_en = 8'h04;
    tick();
    total++; if (lock_ac !== 8'h04) begin bad++; $display("FAIL full_unlock: got %h want 04", lock_ac); end
    unlock_en = 8'h00;
    tick();
    total++; if (lock_ac !== 8'h10) begin bad++; $display("FAIL full_fifth: got %h want 10", lock_ac); end
    lock_en = 8'h00;
  endtask

  task automatic test_lock_reset();
    lock_adr[5] = 10'h010;
    lock_en = 8'h20;
    tick();
    total++; if (lock_ac !== 8'h00) begin bad++; $display("FAIL lrst_held: got %h want 00", lock_ac); end
    reset_n = 1'b0;
    tick();
    total++;
    if (lock_ac !== 8'h00 || mem_ac !== 8'h00 || mem_we !== 1'b0 || mem_adr !== 16'h0 ||
        mem_wdat !== 16'h0) begin
      bad++;
      $display("FAIL lrst_outs: got lock_ac=%h mem_ac=%h we=%b adr=%h wdat=%h want all 0",
               lock_ac, mem_ac, mem_we, mem_adr, mem_wdat);
    end
    reset_n = 1'b1;
    tick();
    total++; if (lock_ac !== 8'h20) begin bad++; $display("FAIL lrst_relock: got %h want 20", lock_ac); end
    clear_inputs();
  endtask
`else
  task automatic test_lock_passthrough();
    pulse_reset();
    lock_adr[1] = 10'h155; lock_adr[5] = 10'h155;
    lock_en = 8'h22;
    tick();
    total++; if (lock_ac !== 8'h02) begin bad++; $display("FAIL pass_first: got %h want 02", lock_ac); end
    lock_en = 8'h20;
    tick();
    total++; if (lock_ac !== 8'h20) begin bad++; $display("FAIL pass_second: got %h want 20", lock_ac); end
    lock_en = 8'h00;
    tick();
    total++; if (lock_ac !== 8'h00) begin bad++; $display("FAIL pass_idle: got %h want 00", lock_ac); end
    unlock_en = 8'h01;
    tick();
    total++; if (lock_ac !== 8'h01) begin bad++; $display("FAIL pass_unlock: got %h want 01", lock_ac); end
    clear_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wr_before_rd();
    test_dual_grant();
`ifdef MEM_LOCK_ARB_LOCK_EN
    test_lock_contend();
    test_lock_full();
    test_lock_reset();
`else
    test_lock_passthrough();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
